twiddle_seq: RTL and testbench
==============================

# twiddle_seq

Twiddle-factor sequencer for the 32-point radix-2 DIT FFT datapath. It is triggered once per transform and walks the 5 stages × 16 butterflies. It drives the enable/address port of the 16-entry twiddle ROM (2-cycle read latency) and buffers the returned words in a 4-entry FIFO. It delivers one twiddle per butterfly to the PE array over a valid/ready handshake, with per-word stage/index sideband.

## Interface
Parameters:
- DATA_WIDTH, 16: width of one real/imag component; twiddle word is 2*DATA_WIDTH (real in upper half).
- ROM_LAT, 2: ROM read latency in cycles, en/addr sampled to data_out valid.
- FIFO_DEPTH, 4: output buffer entries; must be ≥ ROM_LAT+2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a transform; honoured only in IDLE.
- abort  in  1  synchronous flush; returns to IDLE from any state.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse after the 80th twiddle is accepted.
- rom_en  out  1  ROM read enable.
- rom_addr  out  4  ROM address (twiddle index k).
- rom_data  in  2*DATA_WIDTH  ROM registered output.
- tw_valid  out  1  FIFO head valid.
- tw_ready  in  1  consumer accepts head when tw_valid && tw_ready.
- tw_data  out  2*DATA_WIDTH  twiddle word at FIFO head.
- tw_stage  out  3  stage of head word, 0..4.
- tw_last  out  1  head word is the 80th of the transform.

## Operation
- States:
  - IDLE: start goes to RUN and clears the counters.
  - RUN: issues reads; after issuing stage 4 / butterfly 15, goes to DRAIN.
  - DRAIN: waits for in-flight = 0 and FIFO empty, then pulses done and goes to IDLE.
  - abort or rst_n low from any state goes to IDLE.
- Counters: stage s (0..4), butterfly b (0..15). b increments on each issue. When b wraps from 15 to 0, s increments.
- Address: k = (b & (2^s − 1)) << (4 − s). Per stage this gives:
  - s=0: all 0.
  - s=1: 0,8 repeating.
  - s=2: 0,4,8,12.
  - s=3: 0,2,…,14.
  - s=4: 0..15.
- Issue rule: in RUN, rom_en=1 when (fifo_count + inflight) < FIFO_DEPTH. The check uses registered counts and does not count a pop in the same cycle. rom_addr presents k in that cycle. rom_en=0 otherwise, and rom_addr holds its last value.
- In-flight tracking: a ROM_LAT-deep shift register carries valid, stage and last alongside each issue. rom_data is captured into the FIFO only when the tracker's output bit is set.
  - The ROM output register is not gated by en, so untracked cycles must be ignored.
- FIFO: push and pop in the same cycle are both allowed and leave the count unchanged. Push never occurs when full, by construction of the issue rule. tw_* are driven from the head entry.
- abort: clears the state, counters, in-flight tracker and FIFO in the next cycle. ROM words already in the pipe are discarded. done is not pulsed.
- start is ignored while busy. start and abort in the same IDLE cycle: abort wins.
- Reset values: busy=0, done=0, rom_en=0, rom_addr=0, tw_valid=0, tw_data=0, tw_stage=0, tw_last=0; FIFO empty, in-flight clear.

## Timing
- start sampled high in IDLE at cycle 0; first rom_en at cycle 1.
- A read issued at cycle t has rom_data valid during t+ROM_LAT. It is written into the FIFO at the end of that cycle and appears as tw_valid at t+ROM_LAT+1.
- First tw_valid is at cycle 4.
- With tw_ready held at 1, throughput is one twiddle per cycle. Steady state is count=1, inflight=2.
  - Issues occupy cycles 1..80, tw_valid covers cycles 4..83, tw_last is at cycle 83, done pulses at cycle 84 with busy=0 from cycle 84.
- With tw_ready=0 and the FIFO full, rom_en stays 0. Issue resumes the cycle after count+inflight drops below 4.
- done is asserted for exactly one cycle, in the cycle following the pop of the tw_last word.

## Test plan
- Full run, tw_ready=1: start at cycle 0 → 80 words on cycles 4..83.
  - Addresses match the formula for every stage.
  - Stage-4 word 3 = 32'hD4DB_8E40.
  - tw_last only on word 80.
  - done at cycle 84.
- Backpressure: tw_ready=0 from cycle 2 for 20 cycles → exactly 4 issues, FIFO full, no word lost or duplicated. After release, the sequence continues in order, checked against a reference model.
- Random tw_ready (50%) → stream identical to the ready=1 stream; rom_en never asserted while count+inflight=4.
- abort at cycle 30 → IDLE next cycle, tw_valid=0 and busy=0 at cycle 31, no done. A new start then produces a fresh sequence beginning at stage 0, word 0.
- rst_n pulsed low at cycle 40 → all outputs at reset values immediately (asynchronous). A following start runs a complete, correct transform.
- start pulsed at cycle 10 while busy → ignored. Exactly 80 words and a single done.

Source files
------------

// File: rtl/twiddle_seq.sv
// Twiddle-factor sequencer for a 32-point radix-2 DIT FFT: walks 5 stages x 16
// butterflies, reads a latency-ROM_LAT twiddle ROM and streams words to the PEs.
module twiddle_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int ROM_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic                    rom_en,
  output logic [3:0]              rom_addr,
  input  logic [2*DATA_WIDTH-1:0] rom_data,
  output logic                    tw_valid,
  input  logic                    tw_ready,
  output logic [2*DATA_WIDTH-1:0] tw_data,
  output logic [2:0]              tw_stage,
  output logic                    tw_last
);

  localparam int TW_W  = 2 * DATA_WIDTH;
  localparam int ENT_W = TW_W + 4;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = $clog2(FIFO_DEPTH + ROM_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic [2:0]       r_stage;
  logic [3:0]       r_bfly;
  logic [3:0]       r_addr;

  logic [ROM_LAT-1:0] r_trk_vld;
  logic [ROM_LAT-1:0] r_trk_last;
  logic [2:0]         r_trk_stg [ROM_LAT];
  logic [ROM_LAT-1:0] w_trk_vld_in;
  logic [ROM_LAT-1:0] w_trk_last_in;
  logic [2:0]         w_trk_stg_in [ROM_LAT];

  logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic [OCC_W-1:0] w_inflight;
  logic [OCC_W-1:0] w_occ;
  logic [3:0]       w_mask;
  logic [3:0]       w_k;
  logic             w_issue;
  logic             w_issue_last;
  logic             w_push;
  logic             w_pop;
  logic [ENT_W-1:0] w_head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Twiddle index k = (b mod 2^s) * 2^(4-s)
  assign w_mask = 4'((5'd1 << r_stage) - 5'd1);
  assign w_k    = (r_bfly & w_mask) << (3'd4 - r_stage);

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < ROM_LAT; i++) begin
      w_inflight = w_inflight + OCC_W'(r_trk_vld[i]);
    end
  end

  // Registered counts only; a pop in the same cycle does not free a slot.
  assign w_occ        = OCC_W'(r_count) + w_inflight;
  assign w_issue      = (r_state == S_RUN) && !abort && (w_occ < OCC_W'(FIFO_DEPTH));
  assign w_issue_last = (r_stage == 3'd4) && (r_bfly == 4'd15);

  assign w_push = r_trk_vld[ROM_LAT-1];
  assign w_head = r_mem[r_rd_ptr];
  assign w_pop  = tw_valid && tw_ready;

  assign rom_en   = w_issue;
  assign rom_addr = w_issue ? w_k : r_addr;
  assign busy     = r_busy;
  assign done     = r_done;
  assign tw_valid = (r_count != '0);
  assign tw_data  = tw_valid ? w_head[TW_W-1:0] : '0;
  assign tw_stage = tw_valid ? w_head[TW_W+2:TW_W] : 3'd0;
  assign tw_last  = tw_valid & w_head[TW_W+3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_stage <= '0;
      r_bfly  <= '0;
      r_addr  <= '0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_stage <= '0;
        r_bfly  <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
              r_stage <= '0;
              r_bfly  <= '0;
            end
          end
          S_RUN: begin
            if (w_issue) begin
              r_addr <= w_k;
              if (r_bfly == 4'd15) begin
                r_bfly <= '0;
                if (r_stage == 3'd4) begin
                  r_state <= S_DRAIN;
                end else begin
                  r_stage <= r_stage + 3'd1;
                end
              end else begin
                r_bfly <= r_bfly + 4'd1;
              end
            end
          end
          S_DRAIN: begin
            // The last word leaving the FIFO means nothing is left in flight.
            if (w_pop && w_head[TW_W+3]) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ROM_LAT; gi++) begin : g_trk
      if (gi == 0) begin : g_head
        assign w_trk_vld_in[gi]  = w_issue;
        assign w_trk_last_in[gi] = w_issue_last;
        assign w_trk_stg_in[gi]  = r_stage;
      end else begin : g_tail
        assign w_trk_vld_in[gi]  = r_trk_vld[gi-1];
        assign w_trk_last_in[gi] = r_trk_last[gi-1];
        assign w_trk_stg_in[gi]  = r_trk_stg[gi-1];
      end
    end
  endgenerate

  // ROM output register is free-running; only tracked slots carry real reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trk_vld  <= '0;
      r_trk_last <= '0;
      for (int i = 0; i < ROM_LAT; i++) r_trk_stg[i] <= '0;
    end else if (abort) begin
      r_trk_vld  <= '0;
      r_trk_last <= '0;
      for (int i = 0; i < ROM_LAT; i++) r_trk_stg[i] <= '0;
    end else begin
      r_trk_vld  <= w_trk_vld_in;
      r_trk_last <= w_trk_last_in;
      for (int i = 0; i < ROM_LAT; i++) r_trk_stg[i] <= w_trk_stg_in[i];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !abort) begin
      r_mem[r_wr_ptr] <= {r_trk_last[ROM_LAT-1], r_trk_stg[ROM_LAT-1], rom_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (abort) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

endmodule

// File: tb/tb_twiddle_seq.sv
// Bench for twiddle_seq: ROM model, stream monitor and an arithmetic reference
// of the 80-word twiddle order, checked with immediate assertions.
module tb_twiddle_seq;

  localparam int TW    = 32;
  localparam int DEPTH = 4;
  localparam int NW    = 80;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          tw_ready = 1'b0;
  logic          busy, done, rom_en, tw_valid, tw_last;
  logic [3:0]    rom_addr;
  logic [TW-1:0] rom_data, tw_data;
  logic [2:0]    tw_stage;

  twiddle_seq #(.DATA_WIDTH(16), .ROM_LAT(2), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .tw_valid(tw_valid), .tw_ready(tw_ready),
    .tw_data(tw_data), .tw_stage(tw_stage), .tw_last(tw_last)
  );

  always #5 clk = ~clk;

  // Two-cycle ROM whose output register ignores the enable
  logic [TW-1:0] rom_tbl [16];
  logic [TW-1:0] rom_q1;
  always @(posedge clk) begin
    rom_q1   <= rom_tbl[rom_addr];
    rom_data <= rom_q1;
  end

  typedef struct {
    logic [TW-1:0] data;
    logic [2:0]    stage;
    logic          last;
    int            cyc;
  } word_t;

  typedef struct {
    logic [3:0] addr;
    int         cyc;
  } issue_t;

  word_t  pop_q[$];
  issue_t issue_q[$];
  int     done_q[$];
  int     neg_cnt = 0;
  int     outstanding = 0;
  int     viol = 0;
  logic   busy_at_done = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rom_en) begin
        issue_q.push_back('{rom_addr, neg_cnt});
        if (outstanding >= DEPTH) viol <= viol + 1;
      end
      if (tw_valid && tw_ready) pop_q.push_back('{tw_data, tw_stage, tw_last, neg_cnt});
      if (done) begin
        done_q.push_back(neg_cnt);
        busy_at_done <= busy;
      end
      if (abort) outstanding <= 0;
      else outstanding <= outstanding + int'(rom_en) - int'(tw_valid && tw_ready);
    end else begin
      outstanding <= 0;
    end
    neg_cnt <= neg_cnt + 1;
  end

  // Reference: stage s, butterfly b uses k = (b mod 2^s) * (16 / 2^s)
  logic [TW-1:0] exp_data  [NW];
  logic [3:0]    exp_addr  [NW];
  logic [2:0]    exp_stage [NW];
  logic          exp_last  [NW];

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int t0 = 0;
  int ready_mode = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_ready();
    case (ready_mode)
      0:       tw_ready = 1'b1;
      1:       tw_ready = 1'($urandom_range(0, 1));
      default: tw_ready = 1'b0;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    drive_ready();
  endtask

  task automatic begin_run();
    @(posedge clk);
    #1;
    pop_q.delete();
    issue_q.delete();
    done_q.delete();
    t0    = neg_cnt;
    cyc   = 0;
    start = 1'b1;
    drive_ready();
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    while (done_q.size() == 0 && cyc < budget) step();
    chk({tag, "_done_seen"}, 64'(done_q.size() != 0), 64'd1);
    repeat (6) step();
  endtask

  task automatic check_stream(input string tag);
    int n;
    chk({tag, "_word_count"}, 64'(pop_q.size()), 64'(NW));
    n = (pop_q.size() < NW) ? pop_q.size() : NW;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_w%0d_data", tag, i), 64'(pop_q[i].data), 64'(exp_data[i]));
      chk($sformatf("%s_w%0d_stage", tag, i), 64'(pop_q[i].stage), 64'(exp_stage[i]));
      chk($sformatf("%s_w%0d_last", tag, i), 64'(pop_q[i].last), 64'(exp_last[i]));
    end
    n = (issue_q.size() < NW) ? issue_q.size() : NW;
    chk({tag, "_issue_count"}, 64'(issue_q.size()), 64'(NW));
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_i%0d_addr", tag, i), 64'(issue_q[i].addr), 64'(exp_addr[i]));
    end
    chk({tag, "_done_count"}, 64'(done_q.size()), 64'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_rom_en"}, 64'(rom_en), 64'd0);
    chk({tag, "_rom_addr"}, 64'(rom_addr), 64'd0);
    chk({tag, "_tw_valid"}, 64'(tw_valid), 64'd0);
    chk({tag, "_tw_data"}, 64'(tw_data), 64'd0);
    chk({tag, "_tw_stage"}, 64'(tw_stage), 64'd0);
    chk({tag, "_tw_last"}, 64'(tw_last), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    for (int k = 0; k < 16; k++) rom_tbl[k] = $urandom;
    rom_tbl[3] = 32'hD4DB_8E40;
    n = 0;
    for (int s = 0; s < 5; s++) begin
      for (int b = 0; b < 16; b++) begin
        int k;
        k = (b % (1 << s)) * (16 >> s);
        exp_addr[n]  = 4'(k);
        exp_data[n]  = rom_tbl[k];
        exp_stage[n] = 3'(s);
        exp_last[n]  = (n == NW - 1);
        n++;
      end
    end

    // Reset values while held in reset
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post_reset_busy", 64'(busy), 64'd0);

    // Full run with ready held high
    ready_mode = 0;
    begin_run();
    wait_done(200, "full");
    check_stream("full");
    chk("full_first_issue_cyc", 64'(issue_q[0].cyc - t0), 64'd1);
    chk("full_last_issue_cyc", 64'(issue_q[issue_q.size()-1].cyc - t0), 64'd80);
    chk("full_first_valid_cyc", 64'(pop_q[0].cyc - t0), 64'd4);
    chk("full_last_word_cyc", 64'(pop_q[pop_q.size()-1].cyc - t0), 64'd83);
    chk("full_done_cyc", 64'(done_q[0] - t0), 64'd84);
    chk("full_busy_at_done", 64'(busy_at_done), 64'd0);
    if (pop_q.size() > 67) chk("stage4_word3", 64'(pop_q[67].data), 64'h0000_0000_D4DB_8E40);
    else chk("stage4_word3_present", 64'(pop_q.size()), 64'd68);

    // Backpressure: ready low for cycles 2..21
    ready_mode = 0;
    begin_run();
    ready_mode = 2;
    while (cyc < 21) step();
    @(negedge clk);
    #1;
    chk("bp_issues_while_stalled", 64'(issue_q.size()), 64'd4);
    chk("bp_pops_while_stalled", 64'(pop_q.size()), 64'd0);
    chk("bp_fifo_head_valid", 64'(tw_valid), 64'd1);
    chk("bp_rom_en_full", 64'(rom_en), 64'd0);
    ready_mode = 0;
    wait_done(300, "bp");
    check_stream("bp");

    // Random 50% ready
    ready_mode = 1;
    begin_run();
    wait_done(1500, "rand");
    check_stream("rand");
    chk("rand_no_issue_when_full", 64'(viol), 64'd0);

    // Abort at cycle 30
    ready_mode = 0;
    begin_run();
    while (cyc < 30) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_tw_valid", 64'(tw_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_rom_en", 64'(rom_en), 64'd0);
    repeat (10) step();
    chk("abort_no_done", 64'(done_q.size()), 64'd0);
    begin_run();
    wait_done(200, "after_abort");
    check_stream("after_abort");

    // Asynchronous reset at cycle 40
    ready_mode = 0;
    begin_run();
    while (cyc < 40) step();
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    begin_run();
    wait_done(200, "after_reset");
    check_stream("after_reset");

    // start pulsed while busy is ignored
    ready_mode = 0;
    begin_run();
    while (cyc < 10) step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(200, "busy_start");
    repeat (10) step();
    check_stream("busy_start");
    chk("busy_start_done_cyc", 64'(done_q[0] - t0), 64'd84);
    chk("final_no_issue_when_full", 64'(viol), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
